// File: rtl/tia_hsync_counter_pkg.sv
// ============================================================================
// Module : tia_hsync_counter_pkg
// Brief  : Line-event LFSR states, counter width and LFSR step function.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tia_hsync_counter_pkg;

  localparam int LFSR_W = 6;

  localparam logic [LFSR_W-1:0] LINE_END_STATE    = 6'h0A;
  localparam logic [LFSR_W-1:0] HSYNC_SET_STATE   = 6'h0F;
  localparam logic [LFSR_W-1:0] HSYNC_RST_STATE   = 6'h3B;
  localparam logic [LFSR_W-1:0] HBLANK_RST_STATE  = 6'h0E;
  localparam logic [LFSR_W-1:0] HBLANK_LATE_STATE = 6'h3A;
  localparam logic [LFSR_W-1:0] LOCKUP_STATE      = 6'h3F;

  // All-ones never leaves itself under XNOR feedback, so it is forced back to zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    logic [LFSR_W-1:0] nxt;
    nxt = {cur[LFSR_W-2:0], ~(cur[LFSR_W-1] ^ cur[LFSR_W-2])};
    if ((cur == LINE_END_STATE) || (cur == LOCKUP_STATE)) begin
      nxt = '0;
    end
    lfsr_next = nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tia_hsync_counter_phase.sv
// ============================================================================
// Module : tia_hsync_counter_phase
// Brief  : 2-bit colour-clock phase counter with step-advance enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tia_hsync_counter_phase (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       rsync_i,
  output logic [1:0] phase_o,
  output logic       adv_o
);

  logic [1:0] phase_q;
  logic [1:0] phase_d;

  always_comb begin
    phase_d = phase_q + 2'd1;
    if (rsync_i) begin
      phase_d = 2'd0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      phase_q <= 2'd0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;
  assign adv_o   = (phase_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/tia_hsync_counter.sv
// ============================================================================
// Module : tia_hsync_counter
// Brief  : TIA horizontal sync LFSR counter with registered active-low
//          HSYNC/HBLANK set/reset strobes. TIA_HMOVE_LATE_BLANK_EN adds the
//          hmove_late_i late-HBLANK selection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tia_hsync_counter
  import tia_hsync_counter_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              rsync_i,
`ifdef TIA_HMOVE_LATE_BLANK_EN
  input  logic              hmove_late_i,
`endif
  output logic [LFSR_W-1:0] count_o,
  output logic [1:0]        phase_o,
  output logic              shb_n_o,
  output logic              shs_n_o,
  output logic              rhs_n_o,
  output logic              rhb_n_o,
  output logic              line_end_o
);

  logic              adv;
  logic [LFSR_W-1:0] count_q;
  logic [LFSR_W-1:0] count_d;
  logic [LFSR_W-1:0] rhb_state;
  logic              wrap_d;
  logic              wrap_q;
  logic              shb_n_q;
  logic              shs_n_q;
  logic              rhs_n_q;
  logic              rhb_n_q;
  logic              line_end_q;

  tia_hsync_counter_phase u_phase (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .rsync_i (rsync_i),
    .phase_o (phase_o),
    .adv_o   (adv)
  );

`ifdef TIA_HMOVE_LATE_BLANK_EN
  assign rhb_state = hmove_late_i ? HBLANK_LATE_STATE : HBLANK_RST_STATE;
`else
  assign rhb_state = HBLANK_RST_STATE;
`endif

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (rsync_i) begin
      count_d = '0;
    end else if (adv) begin
      count_d = lfsr_next(count_q);
      wrap_d  = (count_q == LINE_END_STATE);
    end
  end

  // Strobes decode the pre-edge count, so they trail count by one clock.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      shb_n_q    <= 1'b1;
      shs_n_q    <= 1'b1;
      rhs_n_q    <= 1'b1;
      rhb_n_q    <= 1'b1;
      line_end_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      shb_n_q    <= ~(count_q == '0);
      shs_n_q    <= ~(count_q == HSYNC_SET_STATE);
      rhs_n_q    <= ~(count_q == HSYNC_RST_STATE);
      rhb_n_q    <= ~(count_q == rhb_state);
      line_end_q <= wrap_q;
    end
  end

  assign count_o    = count_q;
  assign shb_n_o    = shb_n_q;
  assign shs_n_o    = shs_n_q;
  assign rhs_n_o    = rhs_n_q;
  assign rhb_n_o    = rhb_n_q;
  assign line_end_o = line_end_q;

endmodule

`default_nettype wire

// File: tb/tb_tia_hsync_counter.sv
// ============================================================================
// Module : tb_tia_hsync_counter
// Brief  : Self-checking bench for tia_hsync_counter (cycle model scoreboard
//          plus line-event checkpoints).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tia_hsync_counter;
  import tia_hsync_counter_pkg::*;

  typedef struct packed {
    logic [5:0] count;
    logic [1:0] phase;
    logic       shb;
    logic       shs;
    logic       rhs;
    logic       rhb;
    logic       le;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rsync = 1'b0;
  logic       late = 1'b0;
  logic [5:0] count;
  logic [1:0] phase;
  logic       shb_n, shs_n, rhs_n, rhb_n, line_end;

  always #5 clk = ~clk;

  tia_hsync_counter dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .rsync_i      (rsync),
`ifdef TIA_HMOVE_LATE_BLANK_EN
    .hmove_late_i (late),
`endif
    .count_o      (count),
    .phase_o      (phase),
    .shb_n_o      (shb_n),
    .shs_n_o      (shs_n),
    .rhs_n_o      (rhs_n),
    .rhb_n_o      (rhb_n),
    .line_end_o   (line_end)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         ec = 0;
  obs_t       sb[$];
  logic [5:0] tbl[0:56];
  int         m_step = 0;
  logic [1:0] m_ph = 2'd0;
  logic       m_wrap = 1'b0;
  obs_t       m_out;

  // Reference model: tracks the step index within the line; count comes from a table.
  task automatic tick();
    obs_t exp_v, got;
    int   rhb_step;
`ifdef TIA_HMOVE_LATE_BLANK_EN
    rhb_step = late ? 18 : 16;
`else
    rhb_step = 16;
`endif
    if (reset) begin
      m_step = 0; m_ph = 2'd0; m_wrap = 1'b0;
      m_out.shb = 1'b1; m_out.shs = 1'b1; m_out.rhs = 1'b1; m_out.rhb = 1'b1; m_out.le = 1'b0;
    end else begin
      m_out.shb = (m_step != 0);
      m_out.shs = (m_step != 4);
      m_out.rhs = (m_step != 8);
      m_out.rhb = (m_step != rhb_step);
      m_out.le  = m_wrap;
      m_wrap    = 1'b0;
      if (rsync) begin
        m_step = 0; m_ph = 2'd0;
      end else begin
        if (m_ph == 2'd3) begin
          if (m_step == 56) begin
            m_step = 0; m_wrap = 1'b1;
          end else begin
            m_step++;
          end
        end
        m_ph = m_ph + 2'd1;
      end
    end
    m_out.count = tbl[m_step];
    m_out.phase = m_ph;
    sb.push_back(m_out);
    @(posedge clk);
    #1;
    if (reset) ec = 0; else ec++;
    exp_v = sb.pop_front();
    got = {count, phase, shb_n, shs_n, rhs_n, rhb_n, line_end};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL scoreboard edge=%0d actual=%h required=%h", ec, got, exp_v);
    end
  endtask

  task automatic run_to(input int target);
    while (ec < target) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; rsync = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rsync = 1'b0; late = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({count, phase, shb_n, shs_n, rhs_n, rhb_n, line_end} !== 13'b000000_00_1111_0) begin
      n_bad++;
      $display("FAIL reset_vals actual=%h required=%h",
               {count, phase, shb_n, shs_n, rhs_n, rhb_n, line_end}, 13'b000000_00_1111_0);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (shb_n !== 1'b0) begin n_bad++; $display("FAIL shb_edge1 actual=%b required=0", shb_n); end
  endtask

  task automatic test_free_run();
    do_reset();
    run_to(16);
    n_cmp++;
    if (count !== 6'h0F) begin n_bad++; $display("FAIL count_e16 actual=%h required=0f", count); end
    run_to(17);
    n_cmp++;
    if (shs_n !== 1'b0) begin n_bad++; $display("FAIL shs_e17 actual=%b required=0", shs_n); end
    run_to(21);
    n_cmp++;
    if (shs_n !== 1'b1) begin n_bad++; $display("FAIL shs_e21 actual=%b required=1", shs_n); end
    run_to(33);
    n_cmp++;
    if (rhs_n !== 1'b0) begin n_bad++; $display("FAIL rhs_e33 actual=%b required=0", rhs_n); end
    run_to(224);
    n_cmp++;
    if (count !== 6'h0A) begin n_bad++; $display("FAIL count_e224 actual=%h required=0a", count); end
    run_to(228);
    n_cmp++;
    if ({count, line_end} !== 7'b000000_0) begin
      n_bad++; $display("FAIL wrap_e228 actual=%h/%b required=00/0", count, line_end);
    end
    run_to(229);
    n_cmp++;
    if ({line_end, shb_n} !== 2'b10) begin
      n_bad++; $display("FAIL line_end_e229 actual=%b%b required=10", line_end, shb_n);
    end
    run_to(230);
    n_cmp++;
    if (line_end !== 1'b0) begin n_bad++; $display("FAIL line_end_e230 actual=%b required=0", line_end); end
    run_to(233);
    n_cmp++;
    if (shb_n !== 1'b1) begin n_bad++; $display("FAIL shb_e233 actual=%b required=1", shb_n); end
    run_to(470);
  endtask

  task automatic test_rsync();
    do_reset();
    run_to(49);
    n_cmp++;
    if (count !== 6'h3C) begin n_bad++; $display("FAIL count_e49 actual=%h required=3c", count); end
    rsync = 1'b1;
    tick();
    rsync = 1'b0;
    n_cmp++;
    if ({count, phase} !== 8'h00) begin
      n_bad++; $display("FAIL rsync_e50 actual=%h/%h required=00/0", count, phase);
    end
    run_to(66);
    n_cmp++;
    if (shs_n !== 1'b1) begin n_bad++; $display("FAIL shs_e66 actual=%b required=1", shs_n); end
    run_to(67);
    n_cmp++;
    if (shs_n !== 1'b0) begin n_bad++; $display("FAIL shs_e67 actual=%b required=0", shs_n); end
    run_to(71);
    n_cmp++;
    if (shs_n !== 1'b1) begin n_bad++; $display("FAIL shs_e71 actual=%b required=1", shs_n); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_to(10);
    rsync = 1'b1;
    repeat (5) tick();
    rsync = 1'b0;
    n_cmp++;
    if ({count, phase, line_end} !== 9'd0) begin
      n_bad++; $display("FAIL rsync_hold actual=%h/%h/%b required=00/0/0", count, phase, line_end);
    end
    run_to(240);
  endtask

  task automatic test_late_blank();
`ifdef TIA_HMOVE_LATE_BLANK_EN
    late = 1'b1;
    do_reset();
    run_to(65);
    n_cmp++;
    if (rhb_n !== 1'b1) begin n_bad++; $display("FAIL late_rhb_e65 actual=%b required=1", rhb_n); end
    run_to(73);
    n_cmp++;
    if (rhb_n !== 1'b0) begin n_bad++; $display("FAIL late_rhb_e73 actual=%b required=0", rhb_n); end
    run_to(77);
    n_cmp++;
    if (rhb_n !== 1'b1) begin n_bad++; $display("FAIL late_rhb_e77 actual=%b required=1", rhb_n); end
    late = 1'b0;
`endif
    do_reset();
    run_to(65);
    n_cmp++;
    if (rhb_n !== 1'b0) begin n_bad++; $display("FAIL rhb_e65 actual=%b required=0", rhb_n); end
    run_to(68);
    n_cmp++;
    if (rhb_n !== 1'b0) begin n_bad++; $display("FAIL rhb_e68 actual=%b required=0", rhb_n); end
    run_to(69);
    n_cmp++;
    if (rhb_n !== 1'b1) begin n_bad++; $display("FAIL rhb_e69 actual=%b required=1", rhb_n); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_to(100);
    reset = 1'b1; rsync = 1'b1;
    tick();
    n_cmp++;
    if ({count, phase, shb_n, shs_n, rhs_n, rhb_n, line_end} !== 13'b000000_00_1111_0) begin
      n_bad++;
      $display("FAIL reset_mid actual=%h required=%h",
               {count, phase, shb_n, shs_n, rhs_n, rhb_n, line_end}, 13'b000000_00_1111_0);
    end
    reset = 1'b0; rsync = 1'b0;
    tick();
    n_cmp++;
    if (shb_n !== 1'b0) begin n_bad++; $display("FAIL shb_after_mid actual=%b required=0", shb_n); end
  endtask

  task automatic test_lockup();
    logic [5:0] v;
    v = 6'h3F;
    n_cmp++;
    if (lfsr_next(v) !== 6'h00) begin
      n_bad++; $display("FAIL lockup actual=%h required=00", lfsr_next(v));
    end
    v = 6'h1F;
    n_cmp++;
    if (lfsr_next(v) !== 6'h3E) begin
      n_bad++; $display("FAIL lfsr_1f actual=%h required=3e", lfsr_next(v));
    end
  endtask

  initial begin
    tbl[0] = 6'h00;
    for (int i = 1; i < 57; i++) begin
      tbl[i] = {tbl[i-1][4:0], ~(tbl[i-1][5] ^ tbl[i-1][4])};
    end
    test_reset();
    test_free_run();
    test_rsync();
    test_back_to_back();
    test_late_blank();
    test_reset_mid();
    test_lockup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
